// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the M-stage data-memory path: load/store opcodes,
// access-unit FSM encoding and byte-enable patterns.
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (sz)
      SZ_HALF: mis = off[0];
      SZ_WORD: mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_store_align.sv
// Opcode decode for the data-memory path: access size, alignment check,
// byte enables and lane-replicated store data.
module dmem_store_align
  import mips_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  output logic        access_o,
  output logic        is_store_o,
  output logic        misalign_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o
);

  acc_size_e size;

  always_comb begin
    access_o   = 1'b0;
    is_store_o = 1'b0;
    size       = SZ_WORD;
    case (op_i)
      OP_LB, OP_LBU: begin access_o = 1'b1; size = SZ_BYTE; end
      OP_LH, OP_LHU: begin access_o = 1'b1; size = SZ_HALF; end
      OP_LW:         begin access_o = 1'b1; size = SZ_WORD; end
      OP_SB:         begin access_o = 1'b1; is_store_o = 1'b1; size = SZ_BYTE; end
      OP_SH:         begin access_o = 1'b1; is_store_o = 1'b1; size = SZ_HALF; end
      OP_SW:         begin access_o = 1'b1; is_store_o = 1'b1; size = SZ_WORD; end
      default:       begin access_o = 1'b0; end
    endcase
  end

  assign misalign_o = access_o & is_misaligned(size, off_i);

  // Loads always fetch the whole word; the extension stage picks the lane.
  always_comb begin
    be_o    = BE_WORD;
    wdata_o = wdata_i;
    if (is_store_o) begin
      case (size)
        SZ_BYTE: begin
          be_o    = BE_BYTE0 << off_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        SZ_HALF: begin
          be_o    = off_i[1] ? BE_HALF_HI : BE_HALF_LO;
          wdata_o = {2{wdata_i[15:0]}};
        end
        default: begin
          be_o    = BE_WORD;
          wdata_o = wdata_i;
        end
      endcase
    end
  end

endmodule

// File: rtl/dmem_access_unit.sv
// M-stage data-memory front end: issues one aligned load/store over a req/ack
// bus, stalls the pipeline until it completes and returns the raw read word.
//
//  state | meaning
//  IDLE  | no access outstanding; current M-stage instruction evaluated
//  WAIT  | mem_req held, waiting for mem_ack or timeout; pipeline stalled
//  RESP  | access finished; one release cycle, rvalid_o/bus_err_o pulse here
module dmem_access_unit
  import mips_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_m,
  input  logic [5:0]  op_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  input  logic        flush_m,
  output logic        stall_o,
  output logic [31:0] dmout_o,
  output logic [1:0]  byteoff_o,
  output logic        rvalid_o,
  output logic        adel_o,
  output logic        ades_o,
  output logic        bus_err_o,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

  dmem_state_e state_q, state_d;

  logic             al_access, al_store, al_misalign;
  logic [3:0]       al_be;
  logic [31:0]      al_wdata;
  logic             accept, in_idle, in_wait, ack_hit, timeout;

  logic             mem_req_q, mem_we_q;
  logic [3:0]       mem_be_q;
  logic [31:0]      mem_addr_q, mem_wdata_q, dmout_q;
  logic [1:0]       off_q, byteoff_q;
  logic             kill_q, rvalid_q, bus_err_q;
  logic [CNT_W-1:0] cnt_q;

  dmem_store_align u_align (
    .op_i       (op_m),
    .off_i      (addr_m[1:0]),
    .wdata_i    (wdata_m),
    .access_o   (al_access),
    .is_store_o (al_store),
    .misalign_o (al_misalign),
    .be_o       (al_be),
    .wdata_o    (al_wdata)
  );

  assign in_idle = (state_q == ST_IDLE);
  assign in_wait = (state_q == ST_WAIT);
  assign ack_hit = in_wait & mem_ack;
  // counter reads k-1 during the k-th WAIT cycle, so timeout lands on cycle WAIT_LIMIT
  assign timeout = in_wait & ~mem_ack & (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_WAIT;
      ST_WAIT: if (mem_ack || timeout) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    accept  = in_idle & valid_m & al_access & ~al_misalign & ~flush_m;
    stall_o = accept | in_wait;
    adel_o  = in_idle & valid_m & al_access & ~al_store & al_misalign;
    ades_o  = in_idle & valid_m & al_access &  al_store & al_misalign;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0;
      mem_addr_q  <= 32'b0;
      mem_wdata_q <= 32'b0;
      off_q       <= 2'b0;
      byteoff_q   <= 2'b0;
      dmout_q     <= 32'b0;
      kill_q      <= 1'b0;
      cnt_q       <= '0;
      rvalid_q    <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      rvalid_q  <= ack_hit & ~mem_we_q & ~kill_q & ~flush_m;
      bus_err_q <= timeout;
      if (accept) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= al_store;
        mem_be_q    <= al_be;
        mem_addr_q  <= {addr_m[31:2], 2'b00};
        mem_wdata_q <= al_wdata;
        off_q       <= addr_m[1:0];
        kill_q      <= 1'b0;
        cnt_q       <= '0;
      end
      if (in_wait) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (flush_m) kill_q <= 1'b1;
        if (mem_ack) begin
          mem_req_q <= 1'b0;
          dmout_q   <= mem_rdata;
          byteoff_q <= off_q;
        end else if (timeout) begin
          mem_req_q <= 1'b0;
        end
      end
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign dmout_o   = dmout_q;
  assign byteoff_o = byteoff_q;
  assign rvalid_o  = rvalid_q;
  assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: loads, stores, misalignment, flush in WAIT,
// bus timeout with late ack, and async reset in the middle of an access.
module tb_dmem_access_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_m;
  logic [5:0]  op_m;
  logic [31:0] addr_m, wdata_m;
  logic        flush_m;
  logic        stall_o, rvalid_o, adel_o, ades_o, bus_err_o;
  logic [31:0] dmout_o;
  logic [1:0]  byteoff_o;
  logic        mem_req, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_access_unit #(.WAIT_LIMIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_m   (valid_m),
    .op_m      (op_m),
    .addr_m    (addr_m),
    .wdata_m   (wdata_m),
    .flush_m   (flush_m),
    .stall_o   (stall_o),
    .dmout_o   (dmout_o),
    .byteoff_o (byteoff_o),
    .rvalid_o  (rvalid_o),
    .adel_o    (adel_o),
    .ades_o    (ades_o),
    .bus_err_o (bus_err_o),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd);
    valid_m = v;
    op_m    = op;
    addr_m  = a;
    wdata_m = wd;
  endtask

  initial begin
    rst_n = 1'b0; flush_m = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    drive(1'b0, 6'h0, 32'h0, 32'h0);
    #3;
    chk("rst_stall", stall_o, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_dmout", dmout_o, 0);
    tick();
    rst_n = 1'b1;

    // 1: LW 0x100, ack in second WAIT cycle
    tick();
    drive(1'b1, OP_LW, 32'h0000_0100, 32'h0); #1;
    chk("t1_acc_stall", stall_o, 1);
    chk("t1_acc_req", mem_req, 0);
    tick();
    chk("t1_w1_req", mem_req, 1);
    chk("t1_w1_addr", mem_addr, 32'h0000_0100);
    chk("t1_w1_be", mem_be, 4'b1111);
    chk("t1_w1_we", mem_we, 0);
    chk("t1_w1_stall", stall_o, 1);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
    chk("t1_w2_stall", stall_o, 1);
    tick();
    mem_ack = 1'b0; drive(1'b0, 6'h0, 32'h0, 32'h0); #1;
    chk("t1_resp_stall", stall_o, 0);
    chk("t1_resp_rvalid", rvalid_o, 1);
    chk("t1_resp_dmout", dmout_o, 32'hDEAD_BEEF);
    chk("t1_resp_off", byteoff_o, 0);
    chk("t1_resp_req", mem_req, 0);
    tick();
    chk("t1_idle_rvalid", rvalid_o, 0);

    // 2: SB 0x203
    drive(1'b1, OP_SB, 32'h0000_0203, 32'h0000_00A5); #1;
    chk("t2_acc_stall", stall_o, 1);
    chk("t2_acc_ades", ades_o, 0);
    tick();
    chk("t2_w1_be", mem_be, 4'b1000);
    chk("t2_w1_addr", mem_addr, 32'h0000_0200);
    chk("t2_w1_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("t2_w1_we", mem_we, 1);
    mem_ack = 1'b1; mem_rdata = 32'h0;
    tick();
    mem_ack = 1'b0; drive(1'b0, 6'h0, 32'h0, 32'h0); #1;
    chk("t2_resp_rvalid", rvalid_o, 0);
    chk("t2_resp_stall", stall_o, 0);
    tick();
    chk("t2_idle_rvalid", rvalid_o, 0);

    // 3: misaligned LH / SW
    drive(1'b1, OP_LH, 32'h0000_0101, 32'h0); #1;
    chk("t3_lh_adel", adel_o, 1);
    chk("t3_lh_ades", ades_o, 0);
    chk("t3_lh_stall", stall_o, 0);
    tick();
    chk("t3_lh_req", mem_req, 0);
    drive(1'b1, OP_SW, 32'h0000_0102, 32'h1234_5678); #1;
    chk("t3_sw_ades", ades_o, 1);
    chk("t3_sw_adel", adel_o, 0);
    chk("t3_sw_stall", stall_o, 0);
    tick();
    chk("t3_sw_req", mem_req, 0);
    drive(1'b0, 6'h0, 32'h0, 32'h0);

    // 4: LB 0x42, flush in WAIT, ack in third WAIT cycle
    drive(1'b1, OP_LB, 32'h0000_0042, 32'h0); #1;
    chk("t4_acc_stall", stall_o, 1);
    tick();
    chk("t4_w1_be", mem_be, 4'b1111);
    chk("t4_w1_addr", mem_addr, 32'h0000_0040);
    flush_m = 1'b1; #1;
    chk("t4_w1_stall", stall_o, 1);
    tick();
    flush_m = 1'b0;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D; #1;
    chk("t4_w3_req", mem_req, 1);
    tick();
    mem_ack = 1'b0; drive(1'b0, 6'h0, 32'h0, 32'h0); #1;
    chk("t4_resp_rvalid", rvalid_o, 0);
    chk("t4_resp_stall", stall_o, 0);
    chk("t4_resp_dmout", dmout_o, 32'hCAFE_F00D);
    chk("t4_resp_off", byteoff_o, 2);
    tick();
    chk("t4_idle_req", mem_req, 0);
    chk("t4_idle_rvalid", rvalid_o, 0);
    tick();
    chk("t4_idle2_req", mem_req, 0);

    // 5: timeout after 4 WAIT cycles, then late ack
    drive(1'b1, OP_LW, 32'h0000_0300, 32'h0); #1;
    chk("t5_acc_stall", stall_o, 1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("t5_w%0d_req", i), mem_req, 1);
      chk($sformatf("t5_w%0d_berr", i), bus_err_o, 0);
      chk($sformatf("t5_w%0d_stall", i), stall_o, 1);
    end
    tick();
    drive(1'b0, 6'h0, 32'h0, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0; #1;
    chk("t5_resp_berr", bus_err_o, 1);
    chk("t5_resp_req", mem_req, 0);
    chk("t5_resp_stall", stall_o, 0);
    tick();
    chk("t5_idle_berr", bus_err_o, 0);
    chk("t5_idle_rvalid", rvalid_o, 0);
    chk("t5_idle_stall", stall_o, 0);
    tick();
    mem_ack = 1'b0; #1;
    chk("t5_late_dmout", dmout_o, 32'hCAFE_F00D);
    chk("t5_late_rvalid", rvalid_o, 0);
    chk("t5_late_req", mem_req, 0);

    // 6: async reset in WAIT, then a clean LW
    drive(1'b1, OP_LW, 32'h0000_0400, 32'h0);
    tick();
    chk("t6_w1_req", mem_req, 1);
    #2;
    rst_n = 1'b0; drive(1'b0, 6'h0, 32'h0, 32'h0); #1;
    chk("t6_rst_req", mem_req, 0);
    chk("t6_rst_stall", stall_o, 0);
    chk("t6_rst_addr", mem_addr, 0);
    chk("t6_rst_dmout", dmout_o, 0);
    tick();
    rst_n = 1'b1;
    tick();
    drive(1'b1, OP_LW, 32'h0000_0404, 32'h0); #1;
    chk("t6_acc_stall", stall_o, 1);
    tick();
    chk("t6_w1_addr", mem_addr, 32'h0000_0404);
    mem_ack = 1'b1; mem_rdata = 32'h0102_0304;
    tick();
    mem_ack = 1'b0; drive(1'b0, 6'h0, 32'h0, 32'h0); #1;
    chk("t6_resp_rvalid", rvalid_o, 1);
    chk("t6_resp_dmout", dmout_o, 32'h0102_0304);
    chk("t6_resp_stall", stall_o, 0);
    tick();
    chk("t6_idle_rvalid", rvalid_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
